// File: rtl/cell_pos_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cell_pos_fetch: credit-based read sequencer from a cell position memory   |
// | to a valid/ready position stream. Option macro: CELL_FETCH_SKIP_ZERO_EN.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module cell_pos_fetch #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_posx,
  output logic [31:0]           out_posy,
  output logic [31:0]           out_posz,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  busy,
  output logic                  done
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW:0]       c_DEPTH = (c_CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_PNUM  = (ADDR_WIDTH + 1)'(PARTICLE_NUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_last_ptr;
  logic                  r_busy;
  logic                  r_done;

  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [ADDR_WIDTH-1:0] r_pipe_pid [RD_LATENCY];

  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_pid  [FIFO_DEPTH];
  logic [c_PW-1:0]       r_wr_idx;
  logic [c_PW-1:0]       r_rd_idx;
  logic [c_CW-1:0]       r_occ;
  logic [c_CW-1:0]       r_inflight;

  logic                  w_issue;
  logic                  w_ret_vld;
  logic [ADDR_WIDTH-1:0] w_ret_pid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_drain_done;
  logic [ADDR_WIDTH:0]   w_count;

  // Credits cover both buffered entries and reads still in the memory pipeline.
  assign w_issue   = (r_state == S_FETCH) &&
                     (({1'b0, r_inflight} + {1'b0, r_occ}) < c_DEPTH);
  assign w_ret_vld = r_pipe_vld[RD_LATENCY-1];
  assign w_ret_pid = r_pipe_pid[RD_LATENCY-1];
  assign w_full    = (r_occ == c_DEPTH[c_CW-1:0]);
  assign w_pop     = out_valid && out_ready;
  assign w_count   = (particle_count > c_PNUM) ? c_PNUM : particle_count;

`ifdef CELL_FETCH_SKIP_ZERO_EN
  assign w_push = w_ret_vld && (mem_q != '0);
`else
  assign w_push = w_ret_vld;
`endif

  // No return can be pending once inflight is zero, so only the pop matters.
  assign w_drain_done = (r_inflight == '0) &&
                        ((r_occ == '0) || ((r_occ == c_CW'(1)) && w_pop));

  assign mem_rden    = w_issue;
  assign mem_address = r_rd_ptr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign out_valid   = (r_occ != '0);
  assign out_posx    = out_valid ? r_fifo_data[r_rd_idx][31:0]  : 32'd0;
  assign out_posy    = out_valid ? r_fifo_data[r_rd_idx][63:32] : 32'd0;
  assign out_posz    = out_valid ? r_fifo_data[r_rd_idx][95:64] : 32'd0;
  assign out_pid     = out_valid ? r_fifo_pid[r_rd_idx]         : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_last_ptr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (particle_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_last_ptr <= ADDR_WIDTH'(w_count - 1'b1);
              r_rd_ptr   <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            if (r_rd_ptr == r_last_ptr) r_state  <= S_DRAIN;
            else                        r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_pid[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_pid[0] <= r_rd_ptr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_pid[i] <= r_pipe_pid[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_occ      <= '0;
      r_inflight <= '0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + c_CW'(1);
        2'b01:   r_occ <= r_occ - c_CW'(1);
        default: r_occ <= r_occ;
      endcase
      case ({w_issue, w_ret_vld})
        2'b10:   r_inflight <= r_inflight + c_CW'(1);
        2'b01:   r_inflight <= r_inflight - c_CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_idx] <= mem_q;
      r_fifo_pid[r_wr_idx]  <= w_ret_pid;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && w_full));
`endif

endmodule
`default_nettype wire
